wd_fault_logger: RTL and testbench

- Sits directly downstream of the watchdog top level and consumes its WDFAIL and FLSTAT outputs.
- Timestamps each new watchdog failure and stores {FLSTAT, timestamp} in a small FIFO.
- The FIFO is drained by a supervisor over a simple read-strobe interface.
- Also keeps a saturating count of all failures and of dropped entries, so post-mortem diagnosis survives bursts of failures.

---
 rtl/wd_pkg.sv | 16 +
 rtl/wd_fault_logger_if.sv | 36 +++
 rtl/wd_log_fifo.sv | 65 ++++++
 rtl/wd_fault_logger.sv | 96 +++++++++
 tb/tb_wd_fault_logger.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/wd_pkg.sv
// Shared definitions for the watchdog fault logger: entry layout and widths.
// A logged entry is {FLSTAT, timestamp} with the status code in the MSBs.
package wd_pkg;

  localparam int FLSTAT_W = 3;
  localparam int TS_LSB   = 0;

  function automatic int entry_w(input int ts_w);
    return FLSTAT_W + ts_w;
  endfunction

  function automatic int flstat_lsb(input int ts_w);
    return ts_w;
  endfunction

endpackage

// File: rtl/wd_fault_logger_if.sv
// Supervisor-facing bundle of the fault logger: watchdog inputs, read strobe, status.
// master drives WDFAIL/FLSTAT/RD_EN/CLR; slave (the logger) drives the rest.
interface wd_fault_logger_if #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16,
  parameter int CNT_W = 8
);
  import wd_pkg::*;

  // Handshake: RD_EN is a one-cycle pop request honoured only while EMPTY=0;
  // the popped entry appears on RD_DATA with a one-cycle RD_VALID pulse one
  // cycle later, and RD_DATA holds that value until the next pop.
  logic                        WDFAIL;
  logic [FLSTAT_W-1:0]         FLSTAT;
  logic                        RD_EN;
  logic                        CLR;
  logic [entry_w(TS_W)-1:0]    RD_DATA;
  logic                        RD_VALID;
  logic                        EMPTY;
  logic                        FULL;
  logic [$clog2(DEPTH):0]      LEVEL;
  logic [CNT_W-1:0]            FAILCNT;
  logic [CNT_W-1:0]            OVFCNT;
  logic                        OVF_STICKY;

  modport master (
    output WDFAIL, FLSTAT, RD_EN, CLR,
    input  RD_DATA, RD_VALID, EMPTY, FULL, LEVEL, FAILCNT, OVFCNT, OVF_STICKY
  );

  modport slave (
    input  WDFAIL, FLSTAT, RD_EN, CLR,
    output RD_DATA, RD_VALID, EMPTY, FULL, LEVEL, FAILCNT, OVFCNT, OVF_STICKY
  );

endinterface

// File: rtl/wd_log_fifo.sv
// Single-clock synchronous FIFO with registered read data.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module wd_log_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 19
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_din,
  output logic [W-1:0]           o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [W-1:0]  r_dout;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_dout;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage carries no reset; the pointers alone define which slots are live.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/wd_fault_logger.sv
// Timestamps rising edges of the watchdog fail flag into a small FIFO and keeps
// saturating counts of all failures and of entries dropped on overflow.
module wd_fault_logger
  import wd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  wd_fault_logger_if.slave  bus
);

  localparam int ENTRY_W = entry_w(TS_W);
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]    r_ts;
  logic               r_wdfail_q;
  logic               r_rd_valid;
  logic [CNT_W-1:0]   r_failcnt;
  logic [CNT_W-1:0]   r_ovfcnt;
  logic               r_ovf_sticky;

  logic               w_event;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [LVL_W-1:0]   w_level;
  logic [ENTRY_W-1:0] w_din;
  logic [ENTRY_W-1:0] w_dout;

  assign w_event = bus.WDFAIL & ~r_wdfail_q;
  assign w_pop   = bus.RD_EN & ~w_empty;
  // A pop in the same cycle makes room, so a full FIFO only drops without one.
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_drop  = w_event & w_full & ~w_pop;
  assign w_din   = {bus.FLSTAT, r_ts};

  wd_log_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ts         <= '0;
      r_wdfail_q   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_failcnt    <= '0;
      r_ovfcnt     <= '0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_ts       <= r_ts + TS_W'(1);
      r_wdfail_q <= bus.WDFAIL;
      r_rd_valid <= w_pop;
      // A clear coinciding with an event lands on the post-clear count.
      if (bus.CLR) begin
        r_failcnt    <= CNT_W'(w_event);
        r_ovfcnt     <= CNT_W'(w_drop);
        r_ovf_sticky <= w_drop;
      end else begin
        if (w_event && (r_failcnt != CNT_MAX)) begin
          r_failcnt <= r_failcnt + CNT_W'(1);
        end
        if (w_drop && (r_ovfcnt != CNT_MAX)) begin
          r_ovfcnt <= r_ovfcnt + CNT_W'(1);
        end
        r_ovf_sticky <= r_ovf_sticky | w_drop;
      end
    end
  end

  assign bus.RD_DATA    = w_dout;
  assign bus.RD_VALID   = r_rd_valid;
  assign bus.EMPTY      = w_empty;
  assign bus.FULL       = w_full;
  assign bus.LEVEL      = w_level;
  assign bus.FAILCNT    = r_failcnt;
  assign bus.OVFCNT     = r_ovfcnt;
  assign bus.OVF_STICKY = r_ovf_sticky;

endmodule

// File: tb/tb_wd_fault_logger.sv
// Directed bench for wd_fault_logger: capture, ordering, overflow, saturation,
// clear, timestamp wrap and mid-operation reset.
module tb_wd_fault_logger;

  localparam int DEPTH = 8;
  localparam int TS_W  = 16;
  localparam int CNT_W = 8;
  localparam int EW    = 3 + TS_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wd_fault_logger_if #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) bus ();

  wd_fault_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.WDFAIL = 1'b0;
    bus.FLSTAT = 3'd0;
    bus.RD_EN  = 1'b0;
    bus.CLR    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] f);
    bus.WDFAIL = 1'b1;
    bus.FLSTAT = f;
    tick();
    bus.WDFAIL = 1'b0;
    tick();
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_empty",  32'(bus.EMPTY), 32'd1);
    check("rst_full",   32'(bus.FULL), 32'd0);
    check("rst_level",  32'(bus.LEVEL), 32'd0);
    check("rst_rdata",  32'(bus.RD_DATA), 32'd0);
    check("rst_rvalid", 32'(bus.RD_VALID), 32'd0);
    check("rst_fail",   32'(bus.FAILCNT), 32'd0);
    check("rst_ovf",    32'(bus.OVFCNT), 32'd0);
    check("rst_sticky", 32'(bus.OVF_STICKY), 32'd0);

    // held level at ts 0x0010 gives one entry
    repeat (16) tick();
    bus.WDFAIL = 1'b1;
    bus.FLSTAT = 3'b101;
    repeat (20) tick();
    bus.WDFAIL = 1'b0;
    check("hold_level", 32'(bus.LEVEL), 32'd1);
    check("hold_fail",  32'(bus.FAILCNT), 32'd1);
    check("hold_rv0",   32'(bus.RD_VALID), 32'd0);
    bus.RD_EN = 1'b1;
    tick();
    bus.RD_EN = 1'b0;
    check("hold_rv",    32'(bus.RD_VALID), 32'd1);
    check("hold_data",  32'(bus.RD_DATA), 32'h50010);
    tick();
    check("hold_rv_pulse", 32'(bus.RD_VALID), 32'd0);
    check("hold_data_kept", 32'(bus.RD_DATA), 32'h50010);
    check("hold_empty", 32'(bus.EMPTY), 32'd1);

    // fill, overflow by two, drain in order (pulse i lands at ts 2*i)
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pulse(3'(i));
      exp_q.push_back({3'(i), 16'(2 * i)});
    end
    check("fill_full",  32'(bus.FULL), 32'd1);
    check("fill_level", 32'(bus.LEVEL), 32'd8);
    pulse(3'd1);
    pulse(3'd2);
    check("ovf_cnt",    32'(bus.OVFCNT), 32'd2);
    check("ovf_sticky", 32'(bus.OVF_STICKY), 32'd1);
    check("ovf_fail",   32'(bus.FAILCNT), 32'd10);
    check("ovf_level",  32'(bus.LEVEL), 32'd8);
    bus.RD_EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_e = exp_q.pop_front();
      check("drain_data", 32'(bus.RD_DATA), 32'(exp_e));
      check("drain_rv",   32'(bus.RD_VALID), 32'd1);
    end
    bus.RD_EN = 1'b0;
    check("drain_empty", 32'(bus.EMPTY), 32'd1);

    // full with simultaneous event and read: no drop
    do_reset();
    for (int i = 0; i < 8; i++) pulse(3'(i));
    bus.WDFAIL = 1'b1;
    bus.FLSTAT = 3'b010;
    bus.RD_EN  = 1'b1;
    tick();
    bus.WDFAIL = 1'b0;
    bus.RD_EN  = 1'b0;
    check("fpp_ovf",    32'(bus.OVFCNT), 32'd0);
    check("fpp_sticky", 32'(bus.OVF_STICKY), 32'd0);
    check("fpp_level",  32'(bus.LEVEL), 32'd8);
    check("fpp_data",   32'(bus.RD_DATA), 32'h00000);
    check("fpp_rv",     32'(bus.RD_VALID), 32'd1);
    bus.RD_EN = 1'b1;
    repeat (8) tick();
    bus.RD_EN = 1'b0;
    check("fpp_last",   32'(bus.RD_DATA), 32'h20010);

    // read while empty is ignored; event during that read still lands
    bus.RD_EN = 1'b1;
    tick();
    check("erd_rv",     32'(bus.RD_VALID), 32'd0);
    check("erd_data",   32'(bus.RD_DATA), 32'h20010);
    bus.WDFAIL = 1'b1;
    bus.FLSTAT = 3'b110;
    tick();
    bus.WDFAIL = 1'b0;
    bus.RD_EN  = 1'b0;
    check("erd_level",  32'(bus.LEVEL), 32'd1);
    check("erd_rv2",    32'(bus.RD_VALID), 32'd0);
    bus.RD_EN = 1'b1;
    tick();
    bus.RD_EN = 1'b0;
    check("erd_flstat", 32'(bus.RD_DATA[EW-1:TS_W]), 32'd6);

    // saturation, clear with dropped event, plain clear
    do_reset();
    for (int i = 0; i < 255; i++) pulse(3'd0);
    check("sat_fail",   32'(bus.FAILCNT), 32'd255);
    check("sat_ovf",    32'(bus.OVFCNT), 32'd247);
    pulse(3'd0);
    check("sat_hold",   32'(bus.FAILCNT), 32'd255);
    check("sat_ovf2",   32'(bus.OVFCNT), 32'd248);
    bus.WDFAIL = 1'b1;
    bus.CLR    = 1'b1;
    tick();
    bus.WDFAIL = 1'b0;
    bus.CLR    = 1'b0;
    check("clrev_fail",   32'(bus.FAILCNT), 32'd1);
    check("clrev_ovf",    32'(bus.OVFCNT), 32'd1);
    check("clrev_sticky", 32'(bus.OVF_STICKY), 32'd1);
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    check("clr_fail",   32'(bus.FAILCNT), 32'd0);
    check("clr_ovf",    32'(bus.OVFCNT), 32'd0);
    check("clr_sticky", 32'(bus.OVF_STICKY), 32'd0);
    check("clr_level",  32'(bus.LEVEL), 32'd8);

    // timestamp wrap: events at 0xFFFF and 0x0002
    do_reset();
    repeat (65535) tick();
    bus.WDFAIL = 1'b1;
    bus.FLSTAT = 3'b001;
    tick();
    bus.WDFAIL = 1'b0;
    tick();
    tick();
    bus.WDFAIL = 1'b1;
    bus.FLSTAT = 3'b010;
    tick();
    bus.WDFAIL = 1'b0;
    tick();
    check("wrap_level", 32'(bus.LEVEL), 32'd2);
    bus.RD_EN = 1'b1;
    tick();
    check("wrap_ts0",   32'(bus.RD_DATA), 32'h1FFFF);
    tick();
    check("wrap_ts1",   32'(bus.RD_DATA), 32'h20002);
    bus.RD_EN = 1'b0;

    // reset with 3 entries held and a read in flight
    pulse(3'd3);
    pulse(3'd4);
    pulse(3'd5);
    check("mrst_pre",   32'(bus.LEVEL), 32'd3);
    rst = 1'b1;
    bus.RD_EN = 1'b1;
    tick();
    check("mrst_empty", 32'(bus.EMPTY), 32'd1);
    check("mrst_level", 32'(bus.LEVEL), 32'd0);
    check("mrst_fail",  32'(bus.FAILCNT), 32'd0);
    check("mrst_ovf",   32'(bus.OVFCNT), 32'd0);
    check("mrst_rv",    32'(bus.RD_VALID), 32'd0);
    rst = 1'b0;
    bus.RD_EN = 1'b0;
    tick();

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
